// File: rtl/bus_responder_if.sv
// Bus-side signals of bus_responder: request/address/data from the initiator,
// read data and completion strobes back from the responder.
interface bus_responder_if;
   logic [31:0] address;
   logic        memory_read;
   logic        memory_write;
   logic [1:0]  memory_cycle_width;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        bus_ack;
   logic        bus_error;
   logic        busy;

   modport master (
      output address, memory_read, memory_write, memory_cycle_width, data_in,
      input  data_out, bus_ack, bus_error, busy
   );

   modport slave (
      input  address, memory_read, memory_write, memory_cycle_width, data_in,
      output data_out, bus_ack, bus_error, busy
   );
endinterface

// File: rtl/bus_responder.sv
// Memory-backed bus target with programmable wait states, big-endian byte/word
// lanes and rejection of malformed or out-of-range accesses.
module bus_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned DEPTH_LOG2  = 6
) (
   input logic            clock,
   input logic            reset,
   bus_responder_if.slave bus
);
   localparam int unsigned AW = DEPTH_LOG2 + 2;
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic [1:0]    r_width;
   logic          r_write;
   logic [31:0]   r_wdata;
   logic [31:0]   r_data_out;
   logic [31:0]   r_mem [2**DEPTH_LOG2];

   logic          w_any;
   logic          w_legal;
   logic          w_start;
   logic          w_commit;
   logic [4:0]    w_shift;
   logic [31:0]   w_mask;
   logic [31:0]   w_word;

   always_comb begin
      w_any   = bus.memory_read | bus.memory_write;
      w_legal = !(bus.memory_read && bus.memory_write);
      case (bus.memory_cycle_width)
         2'b01:   if (bus.address[0])         w_legal = 1'b0;
         2'b10:   if (bus.address[1:0] != '0) w_legal = 1'b0;
         2'b11:   w_legal = 1'b0;
         default: ;
      endcase
      if ((bus.address >> AW) != '0) w_legal = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.bus_ack   = 1'b0;
      bus.bus_error = 1'b0;
      bus.busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            bus.busy = 1'b0;
            if (w_any) w_next = w_legal ? S_WAIT : S_ERR;
         end
         S_WAIT:  if (r_cnt == '0) w_next = S_ACK;
         S_ACK: begin
            bus.bus_ack = 1'b1;
            w_next      = S_IDLE;
         end
         S_ERR: begin
            bus.bus_error = 1'b1;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_start  = (r_state == S_IDLE) && (w_next == S_WAIT);
   assign w_commit = (r_state == S_WAIT) && (r_cnt == '0);

   // Big-endian lanes: byte 0 sits in bits 31:24, so shift = (3 - addr[1:0]) * 8.
   always_comb begin
      case (r_width)
         2'b00: begin
            w_shift = {~r_addr[1:0], 3'b000};
            w_mask  = 32'h0000_00FF << w_shift;
         end
         2'b01: begin
            w_shift = {~r_addr[1], 4'b0000};
            w_mask  = 32'h0000_FFFF << w_shift;
         end
         default: begin
            w_shift = '0;
            w_mask  = '1;
         end
      endcase
   end

   assign w_word = r_mem[r_addr[AW-1:2]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_addr     <= '0;
         r_width    <= '0;
         r_write    <= 1'b0;
         r_wdata    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_start) begin
            r_cnt   <= WS;
            r_addr  <= bus.address[AW-1:0];
            r_width <= bus.memory_cycle_width;
            r_write <= bus.memory_write;
            r_wdata <= bus.data_in;
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit && !r_write) r_data_out <= (w_word & w_mask) >> w_shift;
      end
   end

   // Storage is deliberately not reset; reset only cancels the pending commit.
   always_ff @(posedge clock) begin
      if (w_commit && r_write)
         r_mem[r_addr[AW-1:2]] <= (w_word & ~w_mask) | ((r_wdata << w_shift) & w_mask);
   end

   assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: three instances (WAIT_STATES 1, 0, 3) driven from
// vector tables through a scoreboard, plus held-request and mid-access reset sequences.
module tb_bus_responder;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] t_addr [3];
   logic [31:0] t_din  [3];
   logic        t_rd   [3];
   logic        t_wr   [3];
   logic [1:0]  t_w    [3];
   logic [31:0] o_dout [3];
   logic        o_ack  [3];
   logic        o_err  [3];
   logic        o_busy [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned WSV = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      bus_responder_if u_if ();
      bus_responder #(.WAIT_STATES(WSV), .DEPTH_LOG2(6)) u_dut (
         .clock (clock),
         .reset (reset),
         .bus   (u_if)
      );
      assign u_if.address            = t_addr[g];
      assign u_if.memory_read        = t_rd[g];
      assign u_if.memory_write       = t_wr[g];
      assign u_if.memory_cycle_width = t_w[g];
      assign u_if.data_in            = t_din[g];
      assign o_dout[g] = u_if.data_out;
      assign o_ack[g]  = u_if.bus_ack;
      assign o_err[g]  = u_if.bus_error;
      assign o_busy[g] = u_if.busy;
   end

   typedef struct {
      int unsigned k;
      logic        rd;
      logic        wr;
      logic [1:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      bit          is_err;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      bit          is_err;
      bit          is_rd;
      logic [31:0] data;
      int unsigned edges;
   } exp_t;

   vec_t        vt[$];
   exp_t        sb[$];
   logic [31:0] last_rd [3];
   int          checks = 0;
   int          errors = 0;

   function automatic int unsigned ws_of(input int unsigned k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 3;
   endfunction

   function automatic vec_t V(input int unsigned k, input logic rd, input logic wr,
                              input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                              input bit is_err, input logic [31:0] data);
      vec_t v;
      v.k = k; v.rd = rd; v.wr = wr; v.w = w; v.a = a; v.d = d;
      v.is_err = is_err; v.data = data;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      exp_t        e;
      bit          seen;
      bit          busy_ok;
      int unsigned n;
      int unsigned k;
      k = v.k;
      @(negedge clock);
      t_addr[k] = v.a; t_din[k] = v.d; t_w[k] = v.w; t_rd[k] = v.rd; t_wr[k] = v.wr;
      e.is_err = v.is_err;
      e.is_rd  = v.rd && !v.wr;
      e.data   = (e.is_rd && !v.is_err) ? v.data : last_rd[k];
      e.edges  = v.is_err ? 1 : ws_of(k) + 2;
      sb.push_back(e);
      seen = 0; busy_ok = 1; n = 0;
      while (!seen && n < 40) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (o_ack[k] || o_err[k]) seen = 1;
         else if (!o_busy[k])      busy_ok = 0;
      end
      t_rd[k] = 1'b0; t_wr[k] = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s timeout: no ack/error within %0d edges", tag, n);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      check({tag, " ack/err"}, {30'b0, o_ack[k], o_err[k]}, e.is_err ? 32'd1 : 32'd2);
      check({tag, " latency"}, 32'(n), 32'(e.edges));
      check({tag, " busy"}, {30'b0, busy_ok, o_busy[k]}, 32'd3);
      check({tag, " data_out"}, o_dout[k], e.data);
      last_rd[k] = e.data;
      @(negedge clock);
      check({tag, " after"}, {29'b0, o_ack[k], o_err[k], o_busy[k]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned acks;
      for (int unsigned i = 0; i < 3; i++) begin
         t_addr[i] = '0; t_din[i] = '0; t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_w[i] = '0;
         last_rd[i] = '0;
      end

      // WS=1 instance: lanes, errors, top word
      vt.push_back(V(0, 0, 1, 2'b10, 32'h10,  32'h12345678, 0, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'h10,  0, 0, 32'h12345678));
      vt.push_back(V(0, 0, 1, 2'b00, 32'h11,  32'h000000AA, 0, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'h10,  0, 0, 32'h12AA5678));
      vt.push_back(V(0, 1, 0, 2'b01, 32'h12,  0, 0, 32'h00005678));
      vt.push_back(V(0, 1, 0, 2'b00, 32'h13,  0, 0, 32'h00000078));
      vt.push_back(V(0, 1, 0, 2'b01, 32'h11,  0, 1, 0));
      vt.push_back(V(0, 0, 1, 2'b10, 32'h12,  32'hDEADBEEF, 1, 0));
      vt.push_back(V(0, 1, 0, 2'b11, 32'h10,  0, 1, 0));
      vt.push_back(V(0, 1, 1, 2'b10, 32'h10,  32'hFFFFFFFF, 1, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'h100, 0, 1, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'h10,  0, 0, 32'h12AA5678));
      vt.push_back(V(0, 0, 1, 2'b10, 32'h14,  32'h11223344, 0, 0));
      vt.push_back(V(0, 0, 1, 2'b01, 32'h16,  32'hCAFEBEEF, 0, 0));
      vt.push_back(V(0, 0, 1, 2'b00, 32'h14,  32'h00000055, 0, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'h14,  0, 0, 32'h5522BEEF));
      vt.push_back(V(0, 1, 0, 2'b00, 32'h15,  0, 0, 32'h00000022));
      vt.push_back(V(0, 1, 0, 2'b01, 32'h14,  0, 0, 32'h00005522));
      vt.push_back(V(0, 0, 1, 2'b10, 32'hFC,  32'hA5A5A5A5, 0, 0));
      vt.push_back(V(0, 1, 0, 2'b10, 32'hFC,  0, 0, 32'hA5A5A5A5));
      vt.push_back(V(0, 1, 0, 2'b00, 32'hFF,  0, 0, 32'h000000A5));
      // WS=0 and WS=3 instances
      vt.push_back(V(1, 0, 1, 2'b10, 32'h40,  32'hCAFEF00D, 0, 0));
      vt.push_back(V(1, 1, 0, 2'b10, 32'h40,  0, 0, 32'hCAFEF00D));
      vt.push_back(V(1, 1, 0, 2'b00, 32'h41,  0, 0, 32'h000000FE));
      vt.push_back(V(1, 1, 0, 2'b01, 32'h41,  0, 1, 0));
      vt.push_back(V(2, 0, 1, 2'b10, 32'h40,  32'hCAFEF00D, 0, 0));
      vt.push_back(V(2, 1, 0, 2'b10, 32'h40,  0, 0, 32'hCAFEF00D));
      vt.push_back(V(2, 1, 0, 2'b01, 32'h42,  0, 0, 32'h0000F00D));
      vt.push_back(V(2, 0, 1, 2'b10, 32'h200, 32'h1, 1, 0));

      repeat (2) @(negedge clock);
      for (int unsigned i = 0; i < 3; i++)
         check($sformatf("reset outputs dut%0d", i),
               {o_ack[i], o_err[i], o_busy[i], 29'b0} | o_dout[i], 32'd0);
      reset = 1'b1;

      foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

      // Request held one cycle past the ack: single access only
      @(negedge clock);
      t_addr[0] = 32'h10; t_w[0] = 2'b10; t_rd[0] = 1'b1;
      acks = 0;
      for (int unsigned i = 1; i <= 8; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (o_ack[0]) acks++;
         if (i == 4) t_rd[0] = 1'b0;
      end
      check("held request ack count", 32'(acks), 32'd1);
      check("held request data_out", o_dout[0], 32'h12AA5678);
      check("held request idle", {31'b0, o_busy[0]}, 32'd0);
      last_rd[0] = 32'h12AA5678;
      run_vec(V(0, 1, 0, 2'b10, 32'h10, 0, 0, 32'h12AA5678), "after held");

      // Reset during the wait phase of a write must not commit it
      run_vec(V(0, 0, 1, 2'b10, 32'h20, 32'h00000000, 0, 0), "clear 0x20");
      run_vec(V(0, 1, 0, 2'b01, 32'h12, 0, 0, 32'h00005678), "load data_out");
      @(negedge clock);
      t_addr[0] = 32'h20; t_w[0] = 2'b10; t_din[0] = 32'hFFFFFFFF; t_wr[0] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("mid-write busy", {31'b0, o_busy[0]}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid-write reset outputs", {o_ack[0], o_err[0], o_busy[0], 29'b0} | o_dout[0], 32'd0);
      t_wr[0] = 1'b0;
      for (int unsigned i = 0; i < 3; i++) last_rd[i] = '0;
      repeat (2) @(negedge clock);
      check("reset held outputs", {o_ack[0], o_err[0], o_busy[0], 29'b0} | o_dout[0], 32'd0);
      reset = 1'b1;
      run_vec(V(0, 1, 0, 2'b10, 32'h20, 0, 0, 32'h00000000), "read 0x20 after reset");
      run_vec(V(0, 1, 0, 2'b10, 32'h14, 0, 0, 32'h5522BEEF), "memory kept over reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The module SHALL have parameter WAIT_STATES, default 1: number of extra cycles inserted before completing a valid access (range 0-15).
REQ-002 The module SHALL have parameter DEPTH_LOG2, default 6: log2 of the number of 32-bit memory words held internally.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 address  input  32  byte address of the access.
REQ-006 memory_read  input  1  read request, held by the initiator until bus_ack or bus_error.
REQ-007 memory_write  input  1  write request, held by the initiator until bus_ack or bus_error.
REQ-008 memory_cycle_width  input  2  access width: 00 byte, 01 word (16 bits), 10 long (32 bits), 11 reserved.
REQ-009 data_in  input  32  write data, right-justified.
REQ-010 data_out  output  32  read data, right-justified and zero-extended, registered.
REQ-011 bus_ack  output  1  one-cycle pulse marking successful completion.
REQ-012 bus_error  output  1  one-cycle pulse marking a rejected access.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The state machine SHALL have four states: IDLE, WAIT, ACK and ERR.
REQ-015 In IDLE, when exactly one of memory_read or memory_write is high and the request is legal, the module SHALL latch address, width, direction and data_in, load the wait counter with WAIT_STATES, and enter WAIT.
REQ-016 In WAIT, the counter SHALL decrement on each edge while it is nonzero.
REQ-017 In WAIT, on the edge where the counter is 0, the module SHALL perform the access and enter ACK with bus_ack high for exactly that one cycle.
REQ-018 The first bus_ack cycle SHALL follow edge E0+WAIT_STATES+1, where E0 is the IDLE edge that sampled the request.
REQ-019 From ACK the module SHALL return to IDLE unconditionally, and a request present during ACK SHALL be ignored; the initiator drops its request on seeing bus_ack.
REQ-020 A request SHALL be illegal, and SHALL cause entry to ERR with bus_error high for one cycle after E0, in each of these cases:
  - memory_read and memory_write are both high;
  - width is 11;
  - a word access has address[0]=1;
  - a long access has address[1:0]!=0;
  - address[31:DEPTH_LOG2+2] is nonzero.
REQ-021 From ERR the module SHALL return to IDLE, memory and data_out SHALL be unchanged, and no wait states SHALL be applied.
REQ-022 Byte lanes SHALL be big-endian:
  - a byte at address[1:0]=0/1/2/3 SHALL use bits 31:24, 23:16, 15:8 and 7:0 respectively;
  - a word at address[1]=0/1 SHALL use bits 31:16 and 15:0 respectively.
REQ-023 A write SHALL modify only the addressed lanes, taking the low bits of data_in; all other bits of the word SHALL be preserved.
REQ-024 A read SHALL load data_out with the addressed lanes shifted to bit 0 and zero-filled above, on the same edge that bus_ack rises.
REQ-025 data_out SHALL hold its value until the next successful read completes.
REQ-026 bus_ack and bus_error SHALL never be high in the same cycle.
REQ-027 Requests arriving while busy SHALL have no effect.

Reset
REQ-028 While reset is low, the module SHALL be in IDLE with bus_ack=0, bus_error=0, busy=0, data_out=0 and the wait counter at 0, regardless of the clock.
REQ-029 Reset asserted mid-access (WAIT or ACK) SHALL abort the access; a write not yet committed in WAIT SHALL NOT modify memory.
REQ-030 Memory contents SHALL NOT be reset.

Verification
REQ-031 Long write then read, WAIT_STATES=1: write 0x12345678 to address 0x10, then read long 0x10 -> bus_ack on the 3rd edge after each request; data_out=0x12345678.
REQ-032 Byte and word lanes: after REQ-031, write byte 0xAA to 0x11, then read long 0x10 -> 0x12AA5678; read word 0x12 -> data_out=0x00005678; read byte 0x13 -> 0x00000078.
REQ-033 Errors: word read at 0x11, long write at 0x12, width 11, read and write both high, and address 0x100 with DEPTH_LOG2=6 -> each gives bus_error one cycle after the request, no bus_ack, memory and data_out unchanged.
REQ-034 WAIT_STATES=0 and WAIT_STATES=3: long read -> bus_ack after the 2nd and 5th edge respectively; busy is high from edge 1 through the ack cycle.
REQ-035 Reset mid-write: drop reset during WAIT of a long write of 0xFFFFFFFF to 0x20 that previously held 0x0 -> outputs go to reset values immediately; a subsequent read of 0x20 returns 0x00000000.
REQ-036 Held request: keep memory_read high through ACK for one extra cycle -> exactly one bus_ack and a single access, then a new access starts from IDLE.
